// File: rtl/sccb_slave.sv
// sccb_slave: SCCB responder that decodes start/stop, ID, sub-address and data phases onto an 8-bit register port
// Ports:
//   clk          system clock, at least 8x the SCCB clock
//   rst          asynchronous active-low reset
//   sccb_c       SCCB clock from the master
//   sccb_d       SCCB data, open-drain (driven low or released)
//   reg_addr     current sub-address, the write target and the read source
//   reg_wr_en    one-clk write strobe
//   reg_wr_data  write data, valid while reg_wr_en is high
//   reg_rd_data  register contents at reg_addr
//   busy         high from a start until the following stop
//   xfer_done    one-clk pulse on a stop that ends a transaction whose ID matched
module sccb_slave #(
  parameter logic [6:0] DEV_ID = 7'h50,
  parameter bit DRIVE_ACK = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sccb_c,
  inout  wire        sccb_d,
  output logic [7:0] reg_addr,
  output logic       reg_wr_en,
  output logic [7:0] reg_wr_data,
  input  logic [7:0] reg_rd_data,
  output logic       busy,
  output logic       xfer_done
);
  typedef enum logic [3:0] {IDLE, ID, ID_X, SUB, SUB_X, WDATA, WDATA_X, RDATA, RDATA_X, IGNORE} state_t;
  state_t state;
  // [0],[1] are the two synchronizer stages, [2] is the history flop used for edge detection
  logic [2:0] c_q, d_q;
  logic [2:0] cnt;
  logic [7:0] sr;
  logic rw, id_ok, xr, drive;
  logic scl_rise, scl_fall, start, stop, last;
  logic [7:0] byte_in;
  assign sccb_d = drive ? 1'b0 : 1'bz;
  assign scl_rise = c_q[1] & ~c_q[2];
  assign scl_fall = ~c_q[1] & c_q[2];
  assign start = c_q[1] & d_q[2] & ~d_q[1];
  assign stop = c_q[1] & ~d_q[2] & d_q[1];
  assign byte_in = {sr[6:0], d_q[1]};
  assign last = cnt == 3'd7;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      c_q <= 3'b111;
      d_q <= 3'b111;
      cnt <= 3'd0;
      sr <= 8'h00;
      rw <= 1'b0;
      id_ok <= 1'b0;
      xr <= 1'b0;
      drive <= 1'b0;
      reg_addr <= 8'h00;
      reg_wr_en <= 1'b0;
      reg_wr_data <= 8'h00;
      busy <= 1'b0;
      xfer_done <= 1'b0;
    end else begin
      c_q <= {c_q[1:0], sccb_c};
      d_q <= {d_q[1:0], sccb_d};
      reg_wr_en <= 1'b0;
      xfer_done <= 1'b0;
      if (start) begin
        state <= ID;
        cnt <= 3'd0;
        busy <= 1'b1;
        drive <= 1'b0;
        id_ok <= 1'b0;
        xr <= 1'b0;
      end else if (stop) begin
        state <= IDLE;
        busy <= 1'b0;
        drive <= 1'b0;
        xfer_done <= id_ok;
        id_ok <= 1'b0;
      end else if (scl_rise) begin
        if (state inside {ID, SUB, WDATA, RDATA}) cnt <= cnt + 3'd1;
        if (state inside {ID, SUB, WDATA}) sr <= byte_in;
        case (state)
          ID: if (last) begin
            if (byte_in[7:1] != DEV_ID) state <= IGNORE;
            else begin
              state <= ID_X;
              rw <= byte_in[0];
              id_ok <= 1'b1;
            end
          end
          // a read waits for the fall after the X bit before loading the first data bit
          ID_X: if (rw) xr <= 1'b1; else state <= SUB;
          SUB: if (last) begin
            reg_addr <= byte_in;
            state <= SUB_X;
          end
          SUB_X: state <= WDATA;
          WDATA: if (last) begin
            reg_wr_data <= byte_in;
            reg_wr_en <= 1'b1;
            state <= WDATA_X;
          end
          WDATA_X, RDATA_X: state <= IGNORE;
          RDATA: if (last) state <= RDATA_X;
          default: ;
        endcase
      end else if (scl_fall) begin
        case (state)
          ID_X: if (rw && xr) begin
            sr <= {reg_rd_data[6:0], 1'b0};
            drive <= ~reg_rd_data[7];
            cnt <= 3'd0;
            state <= RDATA;
          end else drive <= DRIVE_ACK && !rw;
          SUB_X, WDATA_X: drive <= DRIVE_ACK;
          RDATA: begin
            drive <= ~sr[7];
            sr <= {sr[6:0], 1'b0};
          end
          default: drive <= 1'b0;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_sccb_slave.sv
// tb_sccb_slave: directed bench for sccb_slave acting as an SCCB master with a pulled-up data line
module tb_sccb_slave;
  localparam int Q = 5;
  logic clk = 1'b0, rst = 1'b0, scl = 1'b1, m_low = 1'b0;
  wire sda;
  pullup (sda);
  assign sda = m_low ? 1'b0 : 1'bz;
  logic [7:0] reg_addr, reg_wr_data, reg_rd_data;
  logic reg_wr_en, busy, xfer_done;
  logic [7:0] mem [256];
  assign reg_rd_data = mem[reg_addr];
  sccb_slave dut (
    .clk(clk), .rst(rst), .sccb_c(scl), .sccb_d(sda),
    .reg_addr(reg_addr), .reg_wr_en(reg_wr_en), .reg_wr_data(reg_wr_data),
    .reg_rd_data(reg_rd_data), .busy(busy), .xfer_done(xfer_done)
  );
  always #5 clk = ~clk;
  int checks = 0, failures = 0, wr_cnt = 0, done_cnt = 0, drove = 0;
  logic [7:0] wr_addr = 8'h00, wr_data = 8'h00;
  always @(negedge clk) begin
    if (reg_wr_en) begin
      wr_cnt++;
      wr_addr = reg_addr;
      wr_data = reg_wr_data;
    end
    if (xfer_done) done_cnt++;
    if (!m_low && sda == 1'b0) drove++;
  end
  typedef struct {
    logic [7:0] id, sub, dat;
    bit three;
    int wr;
    logic [7:0] addr;
    int done;
    bit acked;
  } vec_t;
  vec_t vt[5];
  task automatic chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic start_c;
    m_low = 1'b0; tick(Q);
    scl = 1'b1; tick(Q);
    m_low = 1'b1; tick(Q);
    scl = 1'b0; tick(Q);
  endtask
  task automatic stop_c;
    m_low = 1'b1; tick(Q);
    scl = 1'b1; tick(Q);
    m_low = 1'b0; tick(Q);
  endtask
  task automatic bit_c(input logic b, output logic s);
    m_low = !b; tick(Q);
    scl = 1'b1; tick(Q);
    s = sda; tick(Q);
    scl = 1'b0; tick(Q);
  endtask
  task automatic byte_w(input logic [7:0] v, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_c(v[i], s);
    bit_c(1'b1, ack);
  endtask
  task automatic byte_r(output logic [7:0] v);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_c(1'b1, s);
      v[i] = s;
    end
    bit_c(1'b1, s);
  endtask
  initial begin
    #10000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int w0, d0;
    logic a;
    logic [7:0] v;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    mem[8'h34] = 8'hC3;
    mem[8'h40] = 8'h96;
    vt[0] = '{8'hA0, 8'h12, 8'h5A, 1'b1, 1, 8'h12, 1, 1'b1};
    vt[1] = '{8'hA0, 8'hFF, 8'h00, 1'b1, 1, 8'hFF, 1, 1'b1};
    vt[2] = '{8'hA0, 8'h00, 8'hFF, 1'b1, 1, 8'h00, 1, 1'b1};
    vt[3] = '{8'hA0, 8'h34, 8'h00, 1'b0, 0, 8'h34, 1, 1'b1};
    vt[4] = '{8'hB0, 8'h55, 8'hAA, 1'b1, 0, 8'h34, 0, 1'b0};
    tick(3);
    chk("rst_sda", int'(sda), 1);
    chk("rst_addr", int'(reg_addr), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_wr_en", int'(reg_wr_en), 0);
    chk("rst_wr_data", int'(reg_wr_data), 0);
    chk("rst_done", int'(xfer_done), 0);
    rst = 1'b1;
    tick(5);
    for (int i = 0; i < 5; i++) begin
      w0 = wr_cnt; d0 = done_cnt; drove = 0;
      start_c;
      chk($sformatf("v%0d_busy", i), int'(busy), 1);
      byte_w(vt[i].id, a);
      chk($sformatf("v%0d_id_ack", i), int'(a), int'(!vt[i].acked));
      byte_w(vt[i].sub, a);
      chk($sformatf("v%0d_sub_ack", i), int'(a), int'(!vt[i].acked));
      if (vt[i].three) begin
        byte_w(vt[i].dat, a);
        chk($sformatf("v%0d_dat_ack", i), int'(a), int'(!vt[i].acked));
      end
      stop_c;
      tick(4);
      chk($sformatf("v%0d_wr_cnt", i), wr_cnt - w0, vt[i].wr);
      if (vt[i].wr != 0) begin
        chk($sformatf("v%0d_wr_addr", i), int'(wr_addr), int'(vt[i].sub));
        chk($sformatf("v%0d_wr_data", i), int'(wr_data), int'(vt[i].dat));
      end
      chk($sformatf("v%0d_addr", i), int'(reg_addr), int'(vt[i].addr));
      chk($sformatf("v%0d_done", i), done_cnt - d0, vt[i].done);
      chk($sformatf("v%0d_busy_end", i), int'(busy), 0);
      chk($sformatf("v%0d_drove", i), int'(drove != 0), int'(vt[i].acked));
    end
    w0 = wr_cnt; d0 = done_cnt;
    start_c;
    byte_w(8'hA1, a);
    chk("rd_id_x", int'(a), 1);
    byte_r(v);
    chk("rd_data", int'(v), 8'hC3);
    stop_c;
    tick(4);
    chk("rd_wr_cnt", wr_cnt - w0, 0);
    chk("rd_done", done_cnt - d0, 1);
    chk("rd_addr", int'(reg_addr), 8'h34);
    w0 = wr_cnt; d0 = done_cnt;
    start_c;
    byte_w(8'hA0, a);
    byte_w(8'h20, a);
    for (int i = 0; i < 4; i++) bit_c(i[0], a);
    stop_c;
    tick(4);
    chk("part_wr_cnt", wr_cnt - w0, 0);
    chk("part_busy", int'(busy), 0);
    chk("part_addr", int'(reg_addr), 8'h20);
    chk("part_done", done_cnt - d0, 1);
    w0 = wr_cnt; d0 = done_cnt;
    start_c;
    byte_w(8'hA0, a);
    byte_w(8'h40, a);
    start_c;
    byte_w(8'hA1, a);
    byte_r(v);
    stop_c;
    tick(4);
    chk("rs_data", int'(v), 8'h96);
    chk("rs_wr_cnt", wr_cnt - w0, 0);
    chk("rs_done", done_cnt - d0, 1);
    start_c;
    byte_w(8'hA1, a);
    bit_c(1'b1, a);
    chk("rr_bit7", int'(a), 1);
    chk("rr_drive", int'(sda), 0);
    #2 rst = 1'b0;
    #1;
    chk("rr_sda", int'(sda), 1);
    chk("rr_addr", int'(reg_addr), 0);
    chk("rr_busy", int'(busy), 0);
    chk("rr_wr_en", int'(reg_wr_en), 0);
    chk("rr_wr_data", int'(reg_wr_data), 0);
    chk("rr_done", int'(xfer_done), 0);
    tick(2);
    m_low = 1'b0;
    scl = 1'b1;
    tick(3);
    rst = 1'b1;
    tick(10);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
